// File: rtl/rst_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rst_seq_ctrl
//  Description : Reset sequencing controller. Synchronizes deassertion of the
//                board-level active-low async reset, then releases the
//                per-domain synchronous resets one at a time, GAP_CYCLES
//                apart. Supports a software reset through a 4-phase req/ack
//                handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_seq_ctrl #(
    parameter int NUM_DOMAINS = 4,
    parameter int GAP_CYCLES  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SOFT_HOLD   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   soft_rst_req_i,
    output logic                   soft_rst_ack_o,
    output logic [NUM_DOMAINS-1:0] domain_rst_o,
    output logic                   rst_done_o,
    output logic [1:0]             state_o
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int HW = $clog2(SOFT_HOLD + 1);
    localparam int IW = $clog2(NUM_DOMAINS + 1);

    localparam logic [GW-1:0] c_gap_last  = GW'(GAP_CYCLES - 1);
    localparam logic [HW-1:0] c_hold_last = HW'(SOFT_HOLD - 1);
    localparam logic [HW-1:0] c_hold_max  = HW'(SOFT_HOLD);
    localparam logic [IW-1:0] c_idx_last  = IW'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_DONE    = 2'd2,
        S_SOFT    = 2'd3
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [GW-1:0]          r_gap,   w_gap_nxt;
    logic [HW-1:0]          r_hold,  w_hold_nxt;
    logic [IW-1:0]          r_idx,   w_idx_nxt;
    logic [NUM_DOMAINS-1:0] r_dom,   w_dom_nxt;
    logic                   r_done,  w_done_nxt;
    logic                   r_ack,   w_ack_nxt;
    logic                   w_sync_out;
    logic                   w_hold_met;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    // The hold counter reaches SOFT_HOLD on the edge that leaves SOFT, so the
    // domains stay asserted for SOFT_HOLD full cycles in SOFT.
    assign w_hold_met = (r_hold >= c_hold_last);

    // Reset-deassertion synchronizer: asserts immediately, releases after
    // SYNC_STAGES clock edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // State and datapath registers; every output is taken from one of these.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_HOLD;
            r_gap   <= '0;
            r_hold  <= '0;
            r_idx   <= '0;
            r_dom   <= '1;
            r_done  <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_gap_nxt;
            r_hold  <= w_hold_nxt;
            r_idx   <= w_idx_nxt;
            r_dom   <= w_dom_nxt;
            r_done  <= w_done_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    // Next-state and next-output logic for the sequencing FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_hold_nxt  = r_hold;
        w_idx_nxt   = r_idx;
        w_dom_nxt   = r_dom;
        w_done_nxt  = r_done;
        w_ack_nxt   = r_ack;

        case (r_state)
            S_HOLD: begin
                if (w_sync_out) begin
                    w_state_nxt = S_RELEASE;
                    w_gap_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end

            S_RELEASE: begin
                if (r_gap == c_gap_last) begin
                    // Domains release strictly in ascending index order.
                    for (int k = 0; k < NUM_DOMAINS; k++) begin
                        if (r_idx == IW'(k)) begin
                            w_dom_nxt[k] = 1'b0;
                        end
                    end
                    w_idx_nxt = r_idx + IW'(1);
                    w_gap_nxt = '0;
                    if (r_idx == c_idx_last) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_gap_nxt = r_gap + GW'(1);
                end
            end

            S_DONE: begin
                if (soft_rst_req_i) begin
                    w_state_nxt = S_SOFT;
                    w_dom_nxt   = '1;
                    w_done_nxt  = 1'b0;
                    w_ack_nxt   = 1'b1;
                    w_hold_nxt  = '0;
                end
            end

            S_SOFT: begin
                if (r_hold != c_hold_max) begin
                    w_hold_nxt = r_hold + HW'(1);
                end
                // Leave only once the minimum hold has elapsed and the
                // requester has dropped its request (4-phase completion).
                if (w_hold_met && !soft_rst_req_i) begin
                    w_state_nxt = S_RELEASE;
                    w_gap_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_ack_nxt   = 1'b0;
                end
            end

            default: begin
                w_state_nxt = S_HOLD;
            end
        endcase
    end

    assign soft_rst_ack_o = r_ack;
    assign domain_rst_o   = r_dom;
    assign rst_done_o     = r_done;
    assign state_o        = r_state;

endmodule
`default_nettype wire

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset sequencing controller for the flop-based datapath blocks (sync-reset and async-reset DFF stages). It synchronizes deassertion of the board-level async reset. It then releases NUM_DOMAINS downstream synchronous reset lines one at a time, separated by GAP_CYCLES, and supports a software-requested reset through a 4-phase req/ack handshake. It sits at the top of each clock domain and drives the `reset` pins of all flop stages beneath it.

Parameters:
NUM_DOMAINS, 4, number of sequenced reset outputs (>=1); domain 0 released first
GAP_CYCLES, 8, clk cycles between successive domain releases (>=1)
SYNC_STAGES, 2, depth of the reset-deassertion synchronizer (>=2)
SOFT_HOLD, 16, minimum clk cycles all domains stay asserted during a soft reset (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; low = reset asserted
soft_rst_req_i  input  1  soft reset request, 4-phase, held high until ack seen
soft_rst_ack_o  output  1  soft reset acknowledge
domain_rst_o  output  NUM_DOMAINS  active-high reset per domain, registered
rst_done_o  output  1  high when all domains are released
state_o  output  2  FSM state: HOLD=0, RELEASE=1, DONE=2, SOFT=3

Behaviour:
- Reset low, asynchronously with no clock needed:
  - domain_rst_o = all ones, rst_done_o = 0, soft_rst_ack_o = 0, state = HOLD.
  - Synchronizer chain, gap counter and domain index are cleared.
- Synchronizer: SYNC_STAGES flops shift in 1 after reset goes high. E_s = the SYNC_STAGES-th rising edge after reset goes high; the sync output is 1 from E_s.
- HOLD: at the first edge with sync output 1 (E_s+1), go to RELEASE with counter = 0 and index = 0.
- RELEASE:
  - Counter increments every cycle.
  - At an edge where counter == GAP_CYCLES-1: clear domain_rst_o[index], index++, counter = 0.
  - Domain k deasserts at edge E_s + (k+1)*GAP_CYCLES + 1.
  - On the edge the last domain deasserts, go to DONE and set rst_done_o = 1 on that same edge.
- Domains only ever deassert in ascending order. A deasserted domain re-asserts only via reset or SOFT.
- DONE: stay while soft_rst_req_i is low. If soft_rst_req_i is sampled high, on the next edge:
  - state = SOFT, domain_rst_o = all ones, rst_done_o = 0, soft_rst_ack_o = 1, hold counter = 0.
- SOFT:
  - Hold counter increments, saturating at SOFT_HOLD.
  - soft_rst_ack_o stays 1.
  - Exit to RELEASE (counter = 0, index = 0, ack = 0 on the same edge) only when the counter has reached SOFT_HOLD and soft_rst_req_i is sampled low.
  - If req stays high, remain in SOFT indefinitely.
- soft_rst_req_i is ignored in HOLD and RELEASE: no ack, no disturbance to timing. A request still high when DONE is entered is accepted on the following edge.
- Reset low in any state, including mid-RELEASE and mid-SOFT, returns to HOLD immediately; the full sequence restarts from the next deassertion.
- All outputs are driven directly from flops; no combinational paths from inputs to outputs.
- Counter widths: clog2(GAP_CYCLES+1), clog2(SOFT_HOLD+1), clog2(NUM_DOMAINS+1).

Test Plan:
Defaults throughout (4 domains, GAP_CYCLES = 8, SYNC_STAGES = 2, SOFT_HOLD = 16), clk period 10.
1. Power-up: reset low 3 cycles -> domain_rst_o = 4'b1111, rst_done_o = 0, state_o = 0. Release reset -> domain_rst_o becomes 1110 / 1100 / 1000 / 0000 at edges 11 / 19 / 27 / 35 after deassertion; rst_done_o = 1 and state_o = 2 at edge 35.
2. Mid-sequence reset: pull reset low at edge 22 (domain_rst_o = 1100) -> 1111 immediately, without waiting for a clk edge; state_o = 0. Re-release -> exact timing of scenario 1 repeats.
3. Soft reset: in DONE, raise req -> next edge ack = 1, domain_rst_o = 1111, rst_done_o = 0, state_o = 3. Drop req 3 cycles later -> SOFT held 16 cycles total, then ack = 0 and state_o = 1. Domains release 8 cycles apart; done after 32 cycles.
4. Long request: hold req high 40 cycles -> ack high and state_o = 3 throughout. Release sequence begins on the edge after req is sampled low.
5. Request during RELEASE: pulse req for 2 cycles at edge 15 after power-up -> no ack, release timing unchanged. Req held high until DONE -> SOFT entered one edge after DONE.
6. Reset during SOFT: assert reset while ack = 1 -> ack = 0 and state_o = 0 immediately, domains 1111. After release, no stale soft request is acted on if req is low.
